// File: rtl/discrete_pkg.sv
// Shared definitions for the discrete audio stages: mixer states, gain format
// default and 16-bit sample limits.
package discrete_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SAT   = 2'd2
    } mixer_state_e;

    localparam int GAIN_FRAC_BITS_DEFAULT = 7;

    localparam logic signed [15:0] SAMPLE_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAMPLE_MIN = 16'sh8000;

endpackage

// File: rtl/signed_saturator.sv
// Clamps a wide signed value into the 16-bit sample range and flags when the
// clamp changed the value.
module signed_saturator
    import discrete_pkg::*;
#(
    parameter int IN_W = 27
) (
    input  logic signed [IN_W-1:0] value_i,
    output logic signed [15:0]     sat_o,
    output logic                   clip_o
);

    localparam logic signed [IN_W-1:0] MAX_W = IN_W'(SAMPLE_MAX);
    localparam logic signed [IN_W-1:0] MIN_W = IN_W'(SAMPLE_MIN);

    always_comb begin
        sat_o  = value_i[15:0];
        clip_o = 1'b0;
        if (value_i > MAX_W) begin
            sat_o  = SAMPLE_MAX;
            clip_o = 1'b1;
        end else if (value_i < MIN_W) begin
            sat_o  = SAMPLE_MIN;
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/weighted_audio_mixer.sv
// Weighted mixer: one shared multiplier walks the snapshotted channels, then the
// accumulated sum is floored, saturated and strobed out.
module weighted_audio_mixer
    import discrete_pkg::*;
#(
    parameter int NUM_INPUTS     = 4,
    parameter int GAIN_FRAC_BITS = GAIN_FRAC_BITS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     audio_clk_en,
    input  logic [NUM_INPUTS*16-1:0] in,
    input  logic [NUM_INPUTS*8-1:0]  gains,
    output logic signed [15:0]       out,
    output logic                     out_valid,
    output logic                     clipped,
    output logic                     overrun
);

    localparam int ACC_W = 25 + $clog2(NUM_INPUTS);
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);

    mixer_state_e              state_q;
    logic [NUM_INPUTS*16-1:0]  samples_q;
    logic [NUM_INPUTS*8-1:0]   gains_q;
    logic signed [24:0]        prod_q;
    logic signed [24:0]        prod_d;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          cnt_q;

    logic signed [15:0]        selSample;
    logic [7:0]                selGain;
    logic signed [ACC_W-1:0]   accShifted;
    logic signed [15:0]        satValue;
    logic                      satClip;

    // The multiplier output is registered, so ACCUM runs one extra cycle to fold
    // in the last channel's product; the selector yields zero on that cycle.
    always_comb begin
        selSample = '0;
        selGain   = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                selSample = samples_q[16*i +: 16];
                selGain   = gains_q[8*i +: 8];
            end
        end
        prod_d = selSample * $signed({1'b0, selGain});
    end

    assign accShifted = acc_q >>> GAIN_FRAC_BITS;

    signed_saturator #(
        .IN_W(ACC_W)
    ) u_sat (
        .value_i(accShifted),
        .sat_o  (satValue),
        .clip_o (satClip)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            samples_q <= '0;
            gains_q   <= '0;
            prod_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            clipped   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            clipped   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (audio_clk_en) begin
                        samples_q <= in;
                        gains_q   <= gains;
                        prod_q    <= '0;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (audio_clk_en) begin
                        overrun <= 1'b1;
                    end
                    prod_q <= prod_d;
                    acc_q  <= acc_q + ACC_W'(prod_q);
                    if (cnt_q == CNT_W'(NUM_INPUTS)) begin
                        state_q <= SAT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SAT: begin
                    if (audio_clk_en) begin
                        overrun <= 1'b1;
                    end
                    out       <= satValue;
                    out_valid <= 1'b1;
                    clipped   <= satClip;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
